// File: rtl/k052109_pkg.sv
// Shared slot map, tile-slot count and CPU access FSM encoding for the
// K052109 tilemap VRAM scheduler.
package k052109_pkg;

    localparam int unsigned SLOT_W         = 3;
    localparam int unsigned NUM_TILE_SLOTS = 6;
    localparam int unsigned CPU_ST_W       = 2;

    localparam logic [SLOT_W-1:0] SLOT_A_CODE = 3'd0;
    localparam logic [SLOT_W-1:0] SLOT_A_ATTR = 3'd1;
    localparam logic [SLOT_W-1:0] SLOT_B_CODE = 3'd2;
    localparam logic [SLOT_W-1:0] SLOT_B_ATTR = 3'd3;
    localparam logic [SLOT_W-1:0] SLOT_F_CODE = 3'd4;
    localparam logic [SLOT_W-1:0] SLOT_F_ATTR = 3'd5;
    localparam logic [SLOT_W-1:0] SLOT_CPU0   = 3'd6;
    localparam logic [SLOT_W-1:0] SLOT_CPU1   = 3'd7;

    localparam logic [CPU_ST_W-1:0] CPU_IDLE      = 2'd0;
    localparam logic [CPU_ST_W-1:0] CPU_ACTIVE    = 2'd1;
    localparam logic [CPU_ST_W-1:0] CPU_WAIT_DROP = 2'd2;

endpackage

// File: rtl/k052109_vram_sched_if.sv
// Bundle of the scheduler's slot/CPU/VRAM-pin signals; the scheduler is the
// slave side, the surrounding chip (or bench) the master side.
interface k052109_vram_sched_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
);
    logic                  SLOT_EN;
    logic                  HBLANK;
    logic [ADDR_W-2:0]     A_ADDR;
    logic [ADDR_W-2:0]     B_ADDR;
    logic [ADDR_W-2:0]     F_ADDR;
    logic                  CPU_REQ;
    logic                  CPU_RDWn;
    logic [ADDR_W-1:0]     CPU_ADDR;
    logic [DATA_W-1:0]     CPU_WD;
    logic                  CPU_ACK;
    logic [DATA_W-1:0]     CPU_RD;
    logic [ADDR_W-1:0]     VRAM_ADDR;
    logic                  VRAM_OEn;
    logic                  VRAM_WEn;
    logic                  VRAM_DRVn;
    logic [DATA_W-1:0]     VRAM_DOUT;
    logic [DATA_W-1:0]     VRAM_DIN;
    logic [5:0]            TILE_STB;
    logic [DATA_W-1:0]     FETCH_DATA;
    logic [2:0]            SLOT;

    modport slave (
        input  SLOT_EN, HBLANK, A_ADDR, B_ADDR, F_ADDR,
        input  CPU_REQ, CPU_RDWn, CPU_ADDR, CPU_WD, VRAM_DIN,
        output CPU_ACK, CPU_RD, VRAM_ADDR, VRAM_OEn, VRAM_WEn, VRAM_DRVn,
        output VRAM_DOUT, TILE_STB, FETCH_DATA, SLOT
    );

    modport master (
        output SLOT_EN, HBLANK, A_ADDR, B_ADDR, F_ADDR,
        output CPU_REQ, CPU_RDWn, CPU_ADDR, CPU_WD, VRAM_DIN,
        input  CPU_ACK, CPU_RD, VRAM_ADDR, VRAM_OEn, VRAM_WEn, VRAM_DRVn,
        input  VRAM_DOUT, TILE_STB, FETCH_DATA, SLOT
    );
endinterface

// File: rtl/k052109_slot_ctr.sv
// 3-bit slot counter, wraps 7->0 on each enabled edge; clears to 7 so the
// first enabled edge after reset enters slot 0.
module k052109_slot_ctr
    import k052109_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [SLOT_W-1:0] slot,
    output logic [SLOT_W-1:0] slot_nxt_c,
    output logic              exit_c
);
    assign slot_nxt_c = slot + SLOT_W'(1);
    // Every enabled edge both ends the current slot and starts the next.
    assign exit_c     = en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= SLOT_CPU1;
        end else if (en) begin
            slot <= slot_nxt_c;
        end
    end
endmodule

// File: rtl/k052109_vram_sched.sv
// Tilemap VRAM slot scheduler: 6 tile fetch slots + 2 CPU slots per cycle,
// all slots CPU-eligible during HBLANK. Pin controls are set at slot entry.
module k052109_vram_sched
    import k052109_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
) (
    input logic                 CK,
    input logic                 CL,
    k052109_vram_sched_if.slave bus
);
    localparam int unsigned LAYER_W = ADDR_W - 1;

    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_nxt_c;
    logic              exit_c;

    k052109_slot_ctr u_slot_ctr (
        .clk        (CK),
        .rst        (CL),
        .en         (bus.SLOT_EN),
        .slot       (slot),
        .slot_nxt_c (slot_nxt_c),
        .exit_c     (exit_c)
    );

    logic [CPU_ST_W-1:0]       state_q, state_d;
    logic                      rdwn_q, rdwn_d;
    logic                      tile_q, tile_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      oen_q, oen_d;
    logic                      wen_q, wen_d;
    logic                      drvn_q, drvn_d;
    logic [DATA_W-1:0]         dout_q, dout_d;
    logic                      ack_q, ack_d;
    logic [DATA_W-1:0]         rd_q, rd_d;
    logic [NUM_TILE_SLOTS-1:0] stb_q, stb_d;
    logic [DATA_W-1:0]         fetch_q, fetch_d;

    logic [LAYER_W-1:0] layer_addr_c;
    logic               eligible_c;

    // Tile index of the layer owning the slot being entered.
    always_comb begin
        case (slot_nxt_c)
            SLOT_A_CODE, SLOT_A_ATTR: layer_addr_c = bus.A_ADDR;
            SLOT_B_CODE, SLOT_B_ATTR: layer_addr_c = bus.B_ADDR;
            SLOT_F_CODE, SLOT_F_ATTR: layer_addr_c = bus.F_ADDR;
            default:                  layer_addr_c = bus.F_ADDR;
        endcase
    end

    assign eligible_c = bus.HBLANK || (slot_nxt_c == SLOT_CPU0) || (slot_nxt_c == SLOT_CPU1);

    always_comb begin
        state_d = state_q;
        rdwn_d  = rdwn_q;
        tile_d  = tile_q;
        addr_d  = addr_q;
        oen_d   = oen_q;
        wen_d   = wen_q;
        drvn_d  = drvn_q;
        dout_d  = dout_q;
        ack_d   = 1'b0;
        rd_d    = rd_q;
        stb_d   = '0;
        fetch_d = fetch_q;

        // The drop wait tracks the CPU handshake on every CK, not only on slot edges.
        if (state_q == CPU_WAIT_DROP && !bus.CPU_REQ) begin
            state_d = CPU_IDLE;
        end

        if (exit_c) begin
            if (tile_q) begin
                fetch_d = bus.VRAM_DIN;
                stb_d   = NUM_TILE_SLOTS'(1) << slot;
            end
            if (state_q == CPU_ACTIVE) begin
                ack_d   = 1'b1;
                state_d = CPU_WAIT_DROP;
                if (rdwn_q) begin
                    rd_d = bus.VRAM_DIN;
                end
            end

            tile_d = 1'b0;
            if (!eligible_c) begin
                tile_d = 1'b1;
                addr_d = {slot_nxt_c[0], layer_addr_c};
                oen_d  = 1'b0;
                wen_d  = 1'b1;
                drvn_d = 1'b1;
            end else if (state_q == CPU_IDLE && bus.CPU_REQ) begin
                state_d = CPU_ACTIVE;
                rdwn_d  = bus.CPU_RDWn;
                addr_d  = bus.CPU_ADDR;
                if (bus.CPU_RDWn) begin
                    oen_d  = 1'b0;
                    wen_d  = 1'b1;
                    drvn_d = 1'b1;
                end else begin
                    oen_d  = 1'b1;
                    wen_d  = 1'b0;
                    drvn_d = 1'b0;
                    dout_d = bus.CPU_WD;
                end
            end else begin
                oen_d  = 1'b1;
                wen_d  = 1'b1;
                drvn_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CK or posedge CL) begin
        if (CL) begin
            state_q <= CPU_IDLE;
            rdwn_q  <= 1'b1;
            tile_q  <= 1'b0;
            addr_q  <= '0;
            oen_q   <= 1'b1;
            wen_q   <= 1'b1;
            drvn_q  <= 1'b1;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            rd_q    <= '0;
            stb_q   <= '0;
            fetch_q <= '0;
        end else begin
            state_q <= state_d;
            rdwn_q  <= rdwn_d;
            tile_q  <= tile_d;
            addr_q  <= addr_d;
            oen_q   <= oen_d;
            wen_q   <= wen_d;
            drvn_q  <= drvn_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
            stb_q   <= stb_d;
            fetch_q <= fetch_d;
        end
    end

    assign bus.SLOT       = slot;
    assign bus.VRAM_ADDR  = addr_q;
    assign bus.VRAM_OEn   = oen_q;
    assign bus.VRAM_WEn   = wen_q;
    assign bus.VRAM_DRVn  = drvn_q;
    assign bus.VRAM_DOUT  = dout_q;
    assign bus.CPU_ACK    = ack_q;
    assign bus.CPU_RD     = rd_q;
    assign bus.TILE_STB   = stb_q;
    assign bus.FETCH_DATA = fetch_q;
endmodule

// File: tb/tb_k052109_vram_sched.sv
// Directed bench for the K052109 VRAM slot scheduler: tile sequence, CPU read,
// HBLANK write, REQ-drop rule, reset mid-access and SLOT_EN stall.
module tb_k052109_vram_sched;

    logic ck;
    logic cl;
    int   vectors;
    int   errors;

    k052109_vram_sched_if #(.ADDR_W(13), .DATA_W(8)) bus ();

    k052109_vram_sched #(.ADDR_W(13), .DATA_W(8)) dut (
        .CK  (ck),
        .CL  (cl),
        .bus (bus)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge ck);
            #1;
        end
    endtask

    logic [12:0] tile_addr [6];
    logic [5:0]  exp_stb;

    initial begin
        vectors = 0;
        errors  = 0;
        tile_addr[0] = 13'h0123; tile_addr[1] = 13'h1123;
        tile_addr[2] = 13'h0045; tile_addr[3] = 13'h1045;
        tile_addr[4] = 13'h07FF; tile_addr[5] = 13'h17FF;

        cl           = 1'b1;
        bus.SLOT_EN  = 1'b1;
        bus.HBLANK   = 1'b0;
        bus.A_ADDR   = 12'h123;
        bus.B_ADDR   = 12'h045;
        bus.F_ADDR   = 12'h7FF;
        bus.CPU_REQ  = 1'b0;
        bus.CPU_RDWn = 1'b1;
        bus.CPU_ADDR = '0;
        bus.CPU_WD   = '0;
        bus.VRAM_DIN = 8'hA7;

        // Reset values
        #11;
        check_eq("rst_slot", bus.SLOT, 3'd7);
        check_eq("rst_addr", bus.VRAM_ADDR, 13'h0);
        check_eq("rst_oen", bus.VRAM_OEn, 1'b1);
        check_eq("rst_wen", bus.VRAM_WEn, 1'b1);
        check_eq("rst_drvn", bus.VRAM_DRVn, 1'b1);
        check_eq("rst_dout", bus.VRAM_DOUT, 8'h00);
        check_eq("rst_ack", bus.CPU_ACK, 1'b0);
        check_eq("rst_rd", bus.CPU_RD, 8'h00);
        check_eq("rst_stb", bus.TILE_STB, 6'h00);
        check_eq("rst_fetch", bus.FETCH_DATA, 8'h00);
        #1 cl = 1'b0;

        // Tile fetch sequence over one full cycle
        for (int i = 0; i < 8; i++) begin
            step(1);
            check_eq("seq_slot", bus.SLOT, 32'(i));
            if (i < 6) begin
                check_eq("seq_addr", bus.VRAM_ADDR, tile_addr[i]);
                check_eq("seq_oen", bus.VRAM_OEn, 1'b0);
            end
            exp_stb = (i >= 1 && i <= 6) ? (6'd1 << (i - 1)) : 6'd0;
            check_eq("seq_stb", bus.TILE_STB, exp_stb);
            if (i >= 1 && i <= 6) check_eq("seq_fetch", bus.FETCH_DATA, 32'(8'hA0 + 8'(i - 1)));
            bus.VRAM_DIN = 8'(8'hA0 + 8'(i));
        end

        // CPU read raised in slot 3, served in slot 6
        step(4);
        check_eq("rd_slot3", bus.SLOT, 3'd3);
        bus.CPU_REQ  = 1'b1;
        bus.CPU_RDWn = 1'b1;
        bus.CPU_ADDR = 13'h0ABC;
        step(1);
        check_eq("rd_s4_addr", bus.VRAM_ADDR, 13'h07FF);
        check_eq("rd_s4_ack", bus.CPU_ACK, 1'b0);
        step(2);
        check_eq("rd_grant_slot", bus.SLOT, 3'd6);
        check_eq("rd_grant_addr", bus.VRAM_ADDR, 13'h0ABC);
        check_eq("rd_grant_oen", bus.VRAM_OEn, 1'b0);
        check_eq("rd_grant_wen", bus.VRAM_WEn, 1'b1);
        check_eq("rd_grant_drvn", bus.VRAM_DRVn, 1'b1);
        check_eq("rd_grant_ack", bus.CPU_ACK, 1'b0);
        bus.VRAM_DIN = 8'h5A;
        step(1);
        check_eq("rd_ack", bus.CPU_ACK, 1'b1);
        check_eq("rd_data", bus.CPU_RD, 8'h5A);
        check_eq("rd_s7_oen", bus.VRAM_OEn, 1'b1);
        check_eq("rd_s7_addr", bus.VRAM_ADDR, 13'h0ABC);

        // REQ held after ACK: no further grants
        step(1);
        check_eq("hold_ack_low", bus.CPU_ACK, 1'b0);
        step(6);
        check_eq("hold_s6_slot", bus.SLOT, 3'd6);
        check_eq("hold_s6_oen", bus.VRAM_OEn, 1'b1);
        check_eq("hold_s6_wen", bus.VRAM_WEn, 1'b1);
        check_eq("hold_s6_addr", bus.VRAM_ADDR, 13'h17FF);
        step(1);
        check_eq("hold_s7_oen", bus.VRAM_OEn, 1'b1);
        check_eq("hold_s7_ack", bus.CPU_ACK, 1'b0);
        bus.CPU_REQ = 1'b0;
        step(1);
        bus.CPU_REQ  = 1'b1;
        bus.CPU_ADDR = 13'h0ABD;
        step(6);
        check_eq("re_grant_slot", bus.SLOT, 3'd6);
        check_eq("re_grant_addr", bus.VRAM_ADDR, 13'h0ABD);
        check_eq("re_grant_oen", bus.VRAM_OEn, 1'b0);
        bus.VRAM_DIN = 8'h3C;
        step(1);
        check_eq("re_ack", bus.CPU_ACK, 1'b1);
        check_eq("re_data", bus.CPU_RD, 8'h3C);
        bus.CPU_REQ = 1'b0;
        bus.HBLANK  = 1'b1;

        // HBLANK write raised in slot 1, served in slot 2
        step(1);
        check_eq("hb_s0_oen", bus.VRAM_OEn, 1'b1);
        check_eq("hb_s0_stb", bus.TILE_STB, 6'h00);
        step(1);
        check_eq("hb_s1_slot", bus.SLOT, 3'd1);
        check_eq("hb_s1_stb", bus.TILE_STB, 6'h00);
        bus.CPU_REQ  = 1'b1;
        bus.CPU_RDWn = 1'b0;
        bus.CPU_ADDR = 13'h1F00;
        bus.CPU_WD   = 8'hC3;
        step(1);
        check_eq("wr_grant_slot", bus.SLOT, 3'd2);
        check_eq("wr_grant_addr", bus.VRAM_ADDR, 13'h1F00);
        check_eq("wr_grant_wen", bus.VRAM_WEn, 1'b0);
        check_eq("wr_grant_drvn", bus.VRAM_DRVn, 1'b0);
        check_eq("wr_grant_oen", bus.VRAM_OEn, 1'b1);
        check_eq("wr_grant_dout", bus.VRAM_DOUT, 8'hC3);
        check_eq("wr_grant_stb", bus.TILE_STB, 6'h00);
        step(1);
        check_eq("wr_ack", bus.CPU_ACK, 1'b1);
        check_eq("wr_rd_kept", bus.CPU_RD, 8'h3C);
        check_eq("wr_s3_wen", bus.VRAM_WEn, 1'b1);
        check_eq("wr_s3_drvn", bus.VRAM_DRVn, 1'b1);
        check_eq("wr_s3_stb", bus.TILE_STB, 6'h00);
        bus.CPU_REQ = 1'b0;
        bus.HBLANK  = 1'b0;
        step(1);
        check_eq("post_hb_addr", bus.VRAM_ADDR, 13'h07FF);
        check_eq("post_hb_oen", bus.VRAM_OEn, 1'b0);
        check_eq("post_hb_stb", bus.TILE_STB, 6'h00);

        // Reset asserted during an active write slot
        step(1);
        bus.CPU_REQ  = 1'b1;
        bus.CPU_RDWn = 1'b0;
        bus.CPU_ADDR = 13'h0155;
        bus.CPU_WD   = 8'h99;
        step(1);
        check_eq("rw_grant_slot", bus.SLOT, 3'd6);
        check_eq("rw_grant_wen", bus.VRAM_WEn, 1'b0);
        check_eq("rw_grant_drvn", bus.VRAM_DRVn, 1'b0);
        #2 cl = 1'b1;
        #1;
        check_eq("rw_rst_wen", bus.VRAM_WEn, 1'b1);
        check_eq("rw_rst_drvn", bus.VRAM_DRVn, 1'b1);
        check_eq("rw_rst_slot", bus.SLOT, 3'd7);
        check_eq("rw_rst_addr", bus.VRAM_ADDR, 13'h0);
        step(1);
        check_eq("rw_rst_ack", bus.CPU_ACK, 1'b0);
        check_eq("rw_rst_slot2", bus.SLOT, 3'd7);
        @(negedge ck);
        cl = 1'b0;
        step(1);
        check_eq("rw_rel_slot", bus.SLOT, 3'd0);
        check_eq("rw_rel_addr", bus.VRAM_ADDR, 13'h0123);
        check_eq("rw_rel_ack", bus.CPU_ACK, 1'b0);
        step(6);
        check_eq("rw_regrant_slot", bus.SLOT, 3'd6);
        check_eq("rw_regrant_addr", bus.VRAM_ADDR, 13'h0155);
        check_eq("rw_regrant_wen", bus.VRAM_WEn, 1'b0);
        check_eq("rw_regrant_dout", bus.VRAM_DOUT, 8'h99);
        step(1);
        check_eq("rw_regrant_ack", bus.CPU_ACK, 1'b1);
        bus.CPU_REQ = 1'b0;

        // SLOT_EN stall in the middle of slot 2
        step(1);
        check_eq("st_ack_low", bus.CPU_ACK, 1'b0);
        step(2);
        check_eq("st_s2_slot", bus.SLOT, 3'd2);
        check_eq("st_s2_addr", bus.VRAM_ADDR, 13'h0045);
        check_eq("st_s2_stb", bus.TILE_STB, 6'b000010);
        bus.SLOT_EN  = 1'b0;
        bus.VRAM_DIN = 8'h77;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_eq("st_hold_slot", bus.SLOT, 3'd2);
            check_eq("st_hold_addr", bus.VRAM_ADDR, 13'h0045);
            check_eq("st_hold_oen", bus.VRAM_OEn, 1'b0);
            check_eq("st_hold_stb", bus.TILE_STB, 6'h00);
        end
        bus.SLOT_EN = 1'b1;
        step(1);
        check_eq("st_res_stb", bus.TILE_STB, 6'b000100);
        check_eq("st_res_fetch", bus.FETCH_DATA, 8'h77);
        check_eq("st_res_slot", bus.SLOT, 3'd3);
        check_eq("st_res_addr", bus.VRAM_ADDR, 13'h1045);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
